lcd_timing_driver: RTL and testbench

//  Final display stage: generates 800x480 LCD raster timing (HS/VS/DE), pulls RGB565 pixels
//  one per clk from the SDRAM read FIFO (after theme-overlay stage) and drives the panel pins.

---
 rtl/lcd_timing_pkg.sv | 42 ++++
 rtl/lcd_axis_counter.sv | 26 ++
 rtl/lcd_timing_driver.sv | 179 +++++++++++++++++
 tb/tb_lcd_timing_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - raster timing constants, FSM states and colour tables for the LCD driver
package lcd_timing_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 21;

  localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam int CNT_W    = 11;

  localparam logic [15:0] UFLOW_COLOR = 16'hF800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lcd_state_t;

  // Colour-bar pattern, left to right
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// rtl/lcd_axis_counter.sv - wrapping raster counter, one instance per axis
module lcd_axis_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = inc && (cnt == max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/lcd_timing_driver.sv
// rtl/lcd_timing_driver.sv - LCD raster timing (HS/VS/DE) and RGB565 pixel pipeline from the read FIFO
// Optional colour-bar test pattern generator compiled in with LCD_TPG_EN.
module lcd_timing_driver #(
  parameter int          H_ACTIVE    = lcd_timing_pkg::H_ACTIVE,
  parameter int          H_FP        = lcd_timing_pkg::H_FP,
  parameter int          H_SYNC      = lcd_timing_pkg::H_SYNC,
  parameter int          H_BP        = lcd_timing_pkg::H_BP,
  parameter int          V_ACTIVE    = lcd_timing_pkg::V_ACTIVE,
  parameter int          V_FP        = lcd_timing_pkg::V_FP,
  parameter int          V_SYNC      = lcd_timing_pkg::V_SYNC,
  parameter int          V_BP        = lcd_timing_pkg::V_BP,
  parameter logic [15:0] UFLOW_COLOR = lcd_timing_pkg::UFLOW_COLOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] fifo_q,
  input  logic        fifo_empty,
  input  logic        uflow_clr,
  input  logic        tpg_sel,
  output logic        fifo_rd,
  output logic        frame_start,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        uflow
);

  import lcd_timing_pkg::*;

  localparam int TOT_H = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int TOT_V = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(TOT_H - 1);
  localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(TOT_V - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_DE_BEG   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_DE_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_DE_BEG   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_DE_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  lcd_state_t       state;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             active;
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_end;
  logic             hs_c;
  logic             vs_c;
  logic             de_c;

  assign active = (state != IDLE);

  lcd_axis_counter #(.W(CNT_W)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!active),
    .inc   (active),
    .max   (H_MAX),
    .cnt   (hcnt),
    .wrap  (h_wrap)
  );

  lcd_axis_counter #(.W(CNT_W)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!active),
    .inc   (h_wrap),
    .max   (V_MAX),
    .cnt   (vcnt),
    .wrap  (v_wrap)
  );

  assign frame_end = h_wrap && v_wrap;

  // Dropping en at the very last pixel goes straight to IDLE rather than draining a whole extra frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= frame_end ? IDLE : DRAIN;
        DRAIN:   if (frame_end) state <= en ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign hs_c = active && (hcnt < H_SYNC_END);
  assign vs_c = active && (vcnt < V_SYNC_END);
  assign de_c = active && (hcnt >= H_DE_BEG) && (hcnt < H_DE_END)
                       && (vcnt >= V_DE_BEG) && (vcnt < V_DE_END);

  assign frame_start = (state == RUN) && (hcnt == '0) && (vcnt == '0);
  assign pix_x       = de_c ? hcnt - H_DE_BEG : '0;
  assign pix_y       = de_c ? vcnt - V_DE_BEG : '0;

  logic        hs_d1;
  logic        vs_d1;
  logic        de_d1;
  logic        uf_d1;
  logic        uf_now;
  logic [15:0] pix_sel;

  assign uf_now = fifo_rd && fifo_empty;

`ifdef LCD_TPG_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic             tpg_act;
  logic             tpg_d1;
  logic [15:0]      bar_d1;
  logic [CNT_W-1:0] bar_q;
  logic [2:0]       bar_idx;

  assign bar_q   = pix_x / CNT_W'(BAR_W);
  assign bar_idx = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];
  assign fifo_rd = de_c && !tpg_act;

  // Pattern selection only changes on frame boundaries so a frame is never mixed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tpg_act <= 1'b0;
      tpg_d1  <= 1'b0;
      bar_d1  <= '0;
    end else begin
      if (frame_start) tpg_act <= tpg_sel;
      tpg_d1 <= tpg_act;
      bar_d1 <= bar_color(bar_idx);
    end
  end

  always_comb begin
    pix_sel = uf_d1 ? UFLOW_COLOR : fifo_q;
    if (tpg_d1) pix_sel = bar_d1;
  end
`else
  logic unused_tpg_sel;

  assign unused_tpg_sel = tpg_sel;
  assign fifo_rd        = de_c;

  always_comb begin
    pix_sel = uf_d1 ? UFLOW_COLOR : fifo_q;
  end
`endif

  // Two-stage pin pipeline: stage 1 waits for fifo_q, stage 2 registers the pins together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d1   <= 1'b0;
      vs_d1   <= 1'b0;
      de_d1   <= 1'b0;
      uf_d1   <= 1'b0;
      lcd_hs  <= 1'b1;
      lcd_vs  <= 1'b1;
      lcd_de  <= 1'b0;
      lcd_rgb <= '0;
      uflow   <= 1'b0;
    end else begin
      hs_d1   <= hs_c;
      vs_d1   <= vs_c;
      de_d1   <= de_c;
      uf_d1   <= uf_now;
      lcd_hs  <= !hs_d1;
      lcd_vs  <= !vs_d1;
      lcd_de  <= de_d1;
      lcd_rgb <= de_d1 ? pix_sel : '0;
      uflow   <= uf_now || (uflow && !uflow_clr);
    end
  end

endmodule

// File: tb/tb_lcd_timing_driver.sv
// tb/tb_lcd_timing_driver.sv - scoreboard and vector bench for lcd_timing_driver on a reduced raster
module tb_lcd_timing_driver;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int FT = HT * VT;
  localparam int NT = 20;
  localparam logic [15:0] UF = 16'hF800;

  logic        clk = 1'b0;
  logic        rst_n, en, fifo_empty, uflow_clr, tpg_sel;
  logic [15:0] fifo_q;
  logic        fifo_rd, frame_start, lcd_hs, lcd_vs, lcd_de, uflow;
  logic [10:0] pix_x, pix_y;
  logic [15:0] lcd_rgb;

  lcd_timing_driver #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .UFLOW_COLOR(UF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .uflow_clr(uflow_clr), .tpg_sel(tpg_sel), .fifo_rd(fifo_rd), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
    .lcd_rgb(lcd_rgb), .uflow(uflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rd, fs, hs, vs, de;
    logic [10:0] px, py;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] rgb;
    bit          uf;
  } sb_t;

  vec_t tbl [NT];
  sb_t  sb [$];

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, pix_idx = 0, ex = -1, ey = -1, uf_hits = 0, tpg_col = 0, tpg_px = 0;
  bit   rd_prev = 0, empty_prev = 0, set_prev = 0, clr_prev = 0;
  bit   clr_req = 0, clr_with_uf = 0, tpg_mode = 0;
  logic uf_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] pix_val(input int i);
    return 16'(i + 256);
  endfunction

  function automatic logic [15:0] bar_exp(input int b);
    case (b)
      0: return 16'hFFFF;  1: return 16'hFFE0;  2: return 16'h07FF;  3: return 16'h07E0;
      4: return 16'hF81F;  5: return 16'hF800;  6: return 16'h001F;  default: return 16'h0000;
    endcase
  endfunction

  // One clock: sample at the falling edge, then drive the inputs for the next rising edge
  task automatic step();
    sb_t e;
    @(negedge clk);
    cyc++;
    if (rd_prev) begin
      if (empty_prev) fifo_q = 16'h1234;
      else begin fifo_q = pix_val(pix_idx); pix_idx++; end
    end
    uf_exp = set_prev | (uf_exp & ~clr_prev);
    check("uflow", 32'(uflow), 32'(uf_exp));
    if (lcd_de) begin
      if (tpg_mode) begin
        check("tpg_rgb", 32'(lcd_rgb), 32'(bar_exp(tpg_col / (HA / 8))));
        tpg_col++; tpg_px++;
      end else if (sb.size() == 0) begin
        check("de_without_read", 32'(lcd_de), 0);
      end else begin
        e = sb.pop_front();
        check("rgb_latency", cyc - e.cyc, 2);
        check("rgb", 32'(lcd_rgb), 32'(e.rgb));
        if (e.uf && lcd_rgb == UF) uf_hits++;
      end
    end else begin
      tpg_col = 0;
      check("rgb_blank", 32'(lcd_rgb), 0);
      while (sb.size() > 0 && cyc - sb[0].cyc >= 2) begin
        e = sb.pop_front();
        check("de_missing", 32'(lcd_de), 1);
      end
    end
    fifo_empty = (ex >= 0) && fifo_rd && (int'(pix_x) == ex) && (int'(pix_y) == ey);
    uflow_clr  = clr_req | (clr_with_uf & fifo_empty);
    if (fifo_rd) sb.push_back('{cyc, fifo_empty ? UF : pix_val(pix_idx), fifo_empty});
    set_prev   = fifo_rd & fifo_empty;
    clr_prev   = uflow_clr;
    rd_prev    = fifo_rd;
    empty_prev = fifo_empty;
  endtask

  task automatic run_frame(input int drop_at, input int clr_at, output int rds, output int fss);
    int   k = 0, hs_falls = 0, hs_bad = 0, hs_low = 0, vs_low = 0, bad_lines = 0;
    int   lrd [VT];
    logic hs_q = 1'b1;
    rds = 0; fss = 0;
    foreach (lrd[i]) lrd[i] = 0;
    for (int c = 0; c < FT; c++) begin
      step();
      if (k < NT && tbl[k].cyc == c) begin
        check($sformatf("rd@%0d", c), 32'(fifo_rd),     32'(tbl[k].rd));
        check($sformatf("fs@%0d", c), 32'(frame_start), 32'(tbl[k].fs));
        check($sformatf("hs@%0d", c), 32'(lcd_hs),      32'(tbl[k].hs));
        check($sformatf("vs@%0d", c), 32'(lcd_vs),      32'(tbl[k].vs));
        check($sformatf("de@%0d", c), 32'(lcd_de),      32'(tbl[k].de));
        check($sformatf("px@%0d", c), 32'(pix_x),       32'(tbl[k].px));
        check($sformatf("py@%0d", c), 32'(pix_y),       32'(tbl[k].py));
        k++;
      end
      if (fifo_rd) begin rds++; lrd[c / HT]++; end
      if (frame_start) fss++;
      if (!lcd_vs) vs_low++;
      if (!lcd_hs) hs_low++;
      if (hs_q && !lcd_hs) begin hs_falls++; if ((c - 2) % HT != 0) hs_bad++; end
      hs_q = lcd_hs;
      if (c == drop_at) en = 1'b0;
      clr_req = (c == clr_at);
      if (clr_at >= 0 && c == clr_at + 2) check("uflow_after_clr", 32'(uflow), 0);
    end
    for (int l = 0; l < VT; l++)
      if (lrd[l] != ((l >= VS + VBP && l < VS + VBP + VA) ? HA : 0)) bad_lines++;
    check("rd_per_line_bad_lines", bad_lines, 0);
    check("hs_fall_count", hs_falls, VT);
    check("hs_period_bad", hs_bad, 0);
    check("hs_low_cycles", hs_low, HS * VT);
    check("vs_low_cycles", vs_low, VS * HT);
  endtask

  initial begin
    int rds, fss, bad;

    tbl[0]  = '{0,   0, 1, 1, 1, 0, 0,  0};
    tbl[1]  = '{1,   0, 0, 1, 1, 0, 0,  0};
    tbl[2]  = '{2,   0, 0, 0, 0, 0, 0,  0};
    tbl[3]  = '{5,   0, 0, 0, 0, 0, 0,  0};
    tbl[4]  = '{6,   0, 0, 1, 0, 0, 0,  0};
    tbl[5]  = '{51,  0, 0, 1, 0, 0, 0,  0};
    tbl[6]  = '{52,  0, 0, 0, 1, 0, 0,  0};
    tbl[7]  = '{106, 0, 0, 1, 1, 0, 0,  0};
    tbl[8]  = '{107, 1, 0, 1, 1, 0, 0,  0};
    tbl[9]  = '{108, 1, 0, 1, 1, 0, 1,  0};
    tbl[10] = '{109, 1, 0, 1, 1, 1, 2,  0};
    tbl[11] = '{122, 1, 0, 1, 1, 1, 15, 0};
    tbl[12] = '{123, 0, 0, 1, 1, 1, 0,  0};
    tbl[13] = '{124, 0, 0, 1, 1, 1, 0,  0};
    tbl[14] = '{125, 0, 0, 1, 1, 0, 0,  0};
    tbl[15] = '{127, 0, 0, 0, 1, 0, 0,  0};
    tbl[16] = '{232, 1, 0, 1, 1, 0, 0,  5};
    tbl[17] = '{240, 1, 0, 1, 1, 1, 8,  5};
    tbl[18] = '{257, 0, 0, 1, 1, 0, 0,  0};
    tbl[19] = '{274, 0, 0, 1, 1, 0, 0,  0};

    rst_n = 1'b0; en = 1'b0; fifo_q = '0; fifo_empty = 1'b0; uflow_clr = 1'b0; tpg_sel = 1'b0;
    step(); step();
    check("rst_fifo_rd", 32'(fifo_rd), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_lcd_de", 32'(lcd_de), 0);
    check("rst_uflow", 32'(uflow), 0);
    check("rst_lcd_hs", 32'(lcd_hs), 1);
    check("rst_lcd_vs", 32'(lcd_vs), 1);
    check("rst_lcd_rgb", 32'(lcd_rgb), 0);
    check("rst_pix_x", 32'(pix_x), 0);
    check("rst_pix_y", 32'(pix_y), 0);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (fifo_rd || frame_start || lcd_de || !lcd_hs || !lcd_vs || lcd_rgb != 0 || pix_x != 0 || pix_y != 0) bad++;
    end
    check("idle_outputs_bad_cycles", bad, 0);

    en = 1'b1;
    run_frame(-1, -1, rds, fss);
    check("rd_per_frame_1", rds, HA * VA);
    check("fs_per_frame_1", fss, 1);

    ex = 10; ey = 5;
    run_frame(-1, -1, rds, fss);
    check("rd_per_frame_2", rds, HA * VA);
    check("fs_per_frame_2", fss, 1);
    check("uflow_pixel_hits", uf_hits, 1);
    check("uflow_sticky", 32'(uflow), 1);

    ex = 3; ey = 2; clr_with_uf = 1'b1;
    run_frame(7 * HT, 5, rds, fss);
    check("rd_per_frame_drain", rds, HA * VA);
    check("fs_per_frame_drain", fss, 1);
    check("uflow_set_wins", 32'(uflow), 1);
    ex = -1; clr_with_uf = 1'b0;

    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (fifo_rd || frame_start || lcd_de || !lcd_hs || !lcd_vs) bad++;
    end
    check("after_drain_idle_bad_cycles", bad, 0);

`ifdef LCD_TPG_EN
    tpg_sel = 1'b1; tpg_mode = 1'b1; tpg_px = 0; en = 1'b1;
    bad = 0;
    for (int c = 0; c < FT; c++) begin
      step();
      if (fifo_rd) bad++;
      if (c == 100) en = 1'b0;
    end
    check("tpg_fifo_rd_count", bad, 0);
    check("tpg_pixel_count", tpg_px, HA * VA);
    tpg_sel = 1'b0; tpg_mode = 1'b0;
    for (int i = 0; i < 5; i++) step();
`endif

    en = 1'b1;
    for (int i = 0; i < 115; i++) step();
    check("mid_frame_reading", 32'(fifo_rd), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_fifo_rd", 32'(fifo_rd), 0);
    check("midrst_lcd_de", 32'(lcd_de), 0);
    check("midrst_lcd_hs", 32'(lcd_hs), 1);
    check("midrst_lcd_vs", 32'(lcd_vs), 1);
    check("midrst_lcd_rgb", 32'(lcd_rgb), 0);
    check("midrst_pix_x", 32'(pix_x), 0);
    check("midrst_uflow", 32'(uflow), 0);
    sb.delete();
    rd_prev = 0; empty_prev = 0; set_prev = 0; clr_prev = 0; uf_exp = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (fifo_rd || frame_start || lcd_de || !lcd_hs || !lcd_vs) bad++;
    end
    check("post_reset_idle_bad_cycles", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
